disp_share_arb: RTL and testbench

Round-robin arbiter that shares the single 4-digit seven-segment display between up to four requesters, such as multiplier operand A, operand B, product high half and product low half. It sits between the datapath blocks and the display scanner. It grants the display to one requester at a time with a guaranteed minimum hold time, so each value stays readable. It also drives the registered 16-bit hex word that the scanner shows.

---
 rtl/disp_share_arb.sv | 94 +++++++++
 tb/tb_disp_share_arb.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/disp_share_arb.sv
// rtl/disp_share_arb.sv - round-robin owner of the shared 4-digit display with minimum hold time
module disp_share_arb #(
    parameter int          HOLD_CYCLES  = 200_000_000,
    parameter logic [15:0] IDLE_PATTERN = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic [63:0] req_data,
    output logic [3:0]  grant,
    output logic        disp_valid,
    output logic [1:0]  disp_sel,
    output logic [15:0] disp_data
);

    localparam int CW = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] HOLD_MAX = CW'(HOLD_CYCLES - 1);

    typedef enum logic {IDLE, OWN} state_t;

    state_t        state;
    logic [1:0]    owner;
    logic [CW-1:0] hold_cnt;

    logic [1:0] win_all, win_oth, idx;
    logic       found_all, found_oth;

    // win_all searches all four starting after owner; win_oth excludes the owner itself
    always_comb begin
        win_all   = owner;
        win_oth   = owner;
        found_all = 1'b0;
        found_oth = 1'b0;
        idx       = owner;
        for (int k = 1; k <= 4; k++) begin
            idx = owner + 2'(k);
            if (!found_all && req[idx]) begin
                found_all = 1'b1;
                win_all   = idx;
            end
            if (k < 4 && !found_oth && req[idx]) begin
                found_oth = 1'b1;
                win_oth   = idx;
            end
        end
    end

    assign disp_sel = owner;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= 2'd3;
            hold_cnt   <= '0;
            grant      <= 4'b0000;
            disp_valid <= 1'b0;
            disp_data  <= IDLE_PATTERN;
        end else begin
            case (state)
                IDLE: begin
                    if (found_all) begin
                        state      <= OWN;
                        owner      <= win_all;
                        grant      <= 4'b0001 << win_all;
                        disp_valid <= 1'b1;
                        hold_cnt   <= '0;
                        disp_data  <= req_data[16*win_all +: 16];
                    end
                end
                OWN: begin
                    if (hold_cnt != HOLD_MAX) begin
                        hold_cnt <= hold_cnt + CW'(1);
                        if (req[owner])
                            disp_data <= req_data[16*owner +: 16];
                    end else if (found_oth) begin
                        owner     <= win_oth;
                        grant     <= 4'b0001 << win_oth;
                        hold_cnt  <= '0;
                        disp_data <= req_data[16*win_oth +: 16];
                    end else if (req[owner]) begin
                        disp_data <= req_data[16*owner +: 16];
                    end else begin
                        state      <= IDLE;
                        grant      <= 4'b0000;
                        disp_valid <= 1'b0;
                        disp_data  <= IDLE_PATTERN;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_disp_share_arb.sv
// tb/tb_disp_share_arb.sv - randomized and directed bench against an ownership-age reference model
module tb_disp_share_arb;

    localparam int          HOLD = 4;
    localparam logic [15:0] IDLE = 16'h0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [63:0] req_data;
    logic [3:0]  grant;
    logic        disp_valid;
    logic [1:0]  disp_sel;
    logic [15:0] disp_data;

    int errors = 0;
    int checks = 0;

    bit          m_busy;
    int          m_owner;
    int          m_age;
    logic [15:0] m_data;

    disp_share_arb #(.HOLD_CYCLES(HOLD), .IDLE_PATTERN(IDLE)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data),
        .grant(grant), .disp_valid(disp_valid), .disp_sel(disp_sel), .disp_data(disp_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int rr(input int from, input logic [3:0] r, input bit incl_self);
        int span = incl_self ? 4 : 3;
        for (int off = 1; off <= span; off++)
            if (r[(from + off) % 4]) return (from + off) % 4;
        return -1;
    endfunction

    function automatic void model_reset();
        m_busy  = 1'b0;
        m_owner = 3;
        m_age   = 0;
        m_data  = IDLE;
    endfunction

    // m_age counts edges the current owner has held the display, including the granting edge
    function automatic void model_step(input logic [3:0] r, input logic [63:0] d);
        int w;
        if (!m_busy) begin
            w = rr(m_owner, r, 1'b1);
            if (w >= 0) begin
                m_busy = 1'b1; m_owner = w; m_age = 1; m_data = d[16*w +: 16];
            end
        end else if (m_age < HOLD) begin
            m_age++;
            if (r[m_owner]) m_data = d[16*m_owner +: 16];
        end else begin
            w = rr(m_owner, r, 1'b0);
            if (w >= 0) begin
                m_owner = w; m_age = 1; m_data = d[16*w +: 16];
            end else if (r[m_owner]) begin
                m_data = d[16*m_owner +: 16];
            end else begin
                m_busy = 1'b0; m_data = IDLE;
            end
        end
    endfunction

    task automatic check_all(input string tag);
        logic [3:0] g;
        g = m_busy ? 4'(1 << m_owner) : 4'b0000;
        chk({tag, ".grant"}, 16'(grant), 16'(g));
        chk({tag, ".valid"}, 16'(disp_valid), 16'(m_busy));
        chk({tag, ".sel"}, 16'(disp_sel), 16'(m_owner));
        chk({tag, ".data"}, disp_data, m_data);
        chk({tag, ".onehot"}, 16'($countones(grant) <= 1), 16'd1);
    endtask

    task automatic cycle(input string tag, input logic [3:0] r,
                         input logic [15:0] d0, input logic [15:0] d1,
                         input logic [15:0] d2, input logic [15:0] d3);
        req      = r;
        req_data = {d3, d2, d1, d0};
        @(posedge clk);
        model_step(r, {d3, d2, d1, d0});
        #1;
        check_all(tag);
    endtask

    task automatic async_reset(input string tag);
        #2 rst = 1'b1;
        model_reset();
        #1;
        check_all(tag);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0] r;
        rst = 1'b1;
        req = 4'b0000;
        req_data = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;

        // reset mid-ownership of requester 2
        cycle("own2", 4'b0100, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
        chk("own2.grant_lit", 16'(grant), 16'h0004);
        cycle("own2b", 4'b0100, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
        async_reset("rst_mid");

        // single requester with live update then release
        cycle("single", 4'b0010, 16'h0, 16'h1234, 16'h0, 16'h0);
        chk("single.data_lit", disp_data, 16'h1234);
        cycle("live", 4'b0010, 16'h0, 16'hABCD, 16'h0, 16'h0);
        chk("live.data_lit", disp_data, 16'hABCD);
        repeat (5) cycle("single_hold", 4'b0010, 16'h0, 16'hABCD, 16'h0, 16'h0);
        cycle("release", 4'b0000, 16'h0, 16'hABCD, 16'h0, 16'h0);
        chk("release.data_lit", disp_data, 16'h0000);

        // round robin with all requesting
        repeat (20) cycle("rr", 4'b1111, 16'hA000, 16'hA001, 16'hA002, 16'hA003);
        cycle("idle", 4'b0000, 16'h0, 16'h0, 16'h0, 16'h0);

        // minimum hold: owner drops after one cycle, requester 2 waits
        async_reset("rst2");
        cycle("mh_g", 4'b0001, 16'h5555, 16'h0, 16'h6666, 16'h0);
        repeat (3) cycle("mh_wait", 4'b0100, 16'h7777, 16'h0, 16'h6666, 16'h0);
        chk("mh.frozen_lit", disp_data, 16'h5555);
        cycle("mh_sw", 4'b0100, 16'h7777, 16'h0, 16'h6666, 16'h0);
        chk("mh.grant_lit", 16'(grant), 16'h0004);

        // owner keeps display, then requester 3 takes it
        repeat (20) cycle("keep", 4'b0100, 16'h0, 16'h0, 16'h1357, 16'h0);
        cycle("take3", 4'b1100, 16'h0, 16'h0, 16'h1357, 16'h2468);
        chk("take3.grant_lit", 16'(grant), 16'h0008);

        // wrap priority from owner 3
        repeat (4) cycle("w3", 4'b1000, 16'h0, 16'h0, 16'h0, 16'h9999);
        cycle("wrap", 4'b1011, 16'hC0DE, 16'hBEEF, 16'h0, 16'h9999);
        chk("wrap.grant_lit", 16'(grant), 16'h0001);

        // randomized traffic with occasional async reset
        r = 4'b0000;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 150) == 0) async_reset("rnd_rst");
            cycle("rnd", r, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
